// File: rtl/rename_regfile_ckpt.sv
// Renaming register file: per-register {value, valid, tag}, multi-slot operand read with
// CDB bypass and intra-bundle forwarding, plus CDB-snooping checkpoints for mispredict recovery.
module rename_regfile_ckpt #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 8,
  parameter int ISSUE_W  = 2,
  parameter int CDB_W    = 4,
  parameter int NUM_CKPT = 4,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(NUM_REGS),
  localparam int CW = $clog2(NUM_CKPT)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [ISSUE_W-1:0]         issue_valid,
  input  logic [ISSUE_W*AW-1:0]      addr_rs1,
  input  logic [ISSUE_W*AW-1:0]      addr_rs2,
  input  logic [ISSUE_W*AW-1:0]      addr_rd,
  input  logic [ISSUE_W-1:0]         rd_we,
  input  logic [ISSUE_W*TAG_W-1:0]   rd_tag,
  output logic [ISSUE_W*DATA_W-1:0]  dout_rs1,
  output logic [ISSUE_W*DATA_W-1:0]  dout_rs2,
  output logic [ISSUE_W-1:0]         dtype_rs1,
  output logic [ISSUE_W-1:0]         dtype_rs2,
  input  logic [CDB_W*TAG_W-1:0]     cdb_tag,
  input  logic [CDB_W*DATA_W-1:0]    cdb_data,
  input  logic                       ckpt_save,
  input  logic [CW-1:0]              ckpt_save_id,
  input  logic                       ckpt_restore,
  input  logic [CW-1:0]              ckpt_restore_id,
  output logic [AW:0]                busy_count
);

  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic              valid;
    logic [TAG_W-1:0]  tag;
  } ent_t;

  ent_t rf    [NUM_REGS];
  ent_t rf_nx [NUM_REGS];
  ent_t ck    [NUM_CKPT][NUM_REGS];
  ent_t ck_nx [NUM_CKPT][NUM_REGS];
  logic [AW:0] busy_nx;

  logic [AW-1:0]     rs1_a [ISSUE_W];
  logic [AW-1:0]     rs2_a [ISSUE_W];
  logic [AW-1:0]     rd_a  [ISSUE_W];
  logic [TAG_W-1:0]  tag_a [ISSUE_W];
  logic [TAG_W-1:0]  cdb_t [CDB_W];
  logic [DATA_W-1:0] cdb_d [CDB_W];

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_unpack_slot
    assign rs1_a[k] = addr_rs1[k*AW +: AW];
    assign rs2_a[k] = addr_rs2[k*AW +: AW];
    assign rd_a[k]  = addr_rd[k*AW +: AW];
    assign tag_a[k] = rd_tag[k*TAG_W +: TAG_W];
  end
  for (genvar c = 0; c < CDB_W; c++) begin : g_unpack_cdb
    assign cdb_t[c] = cdb_tag[c*TAG_W +: TAG_W];
    assign cdb_d[c] = cdb_data[c*DATA_W +: DATA_W];
  end

  // Resolve a pending entry against the CDB; lowest channel wins on duplicate tags.
  function automatic ent_t snoop(ent_t e);
    ent_t r;
    logic hit;
    r   = e;
    hit = 1'b0;
    for (int c = 0; c < CDB_W; c++) begin
      if (!hit && !e.valid && cdb_t[c] != '0 && cdb_t[c] == e.tag) begin
        r.value = cdb_d[c];
        r.valid = 1'b1;
        r.tag   = '0;
        hit     = 1'b1;
      end
    end
    return r;
  endfunction

  // Returns {dtype, data} for slot k reading register s.
  function automatic logic [DATA_W:0] rd_op(int k, logic [AW-1:0] s);
    logic [DATA_W:0]  r;
    logic             fwd;
    logic [TAG_W-1:0] ftag;
    ent_t             e;
    fwd  = 1'b0;
    ftag = '0;
    for (int j = 0; j < ISSUE_W; j++) begin
      if (j < k && issue_valid[j] && rd_we[j] && rd_a[j] == s) begin
        fwd  = 1'b1;
        ftag = tag_a[j];
      end
    end
    e = snoop(rf[s]);
    if (!issue_valid[k])               r = '0;
    else if (ZERO_REG != 0 && s == '0) r = '0;
    else if (fwd)                      r = {1'b1, DATA_W'(ftag)};
    else if (e.valid)                  r = {1'b0, e.value};
    else                               r = {1'b1, DATA_W'(e.tag)};
    return r;
  endfunction

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_read
    logic [DATA_W:0] op1, op2;
    assign op1 = rd_op(k, rs1_a[k]);
    assign op2 = rd_op(k, rs2_a[k]);
    assign dout_rs1[k*DATA_W +: DATA_W] = op1[DATA_W-1:0];
    assign dout_rs2[k*DATA_W +: DATA_W] = op2[DATA_W-1:0];
    assign dtype_rs1[k] = op1[DATA_W];
    assign dtype_rs2[k] = op2[DATA_W];
  end

  always_comb begin
    for (int c = 0; c < NUM_CKPT; c++)
      for (int r = 0; r < NUM_REGS; r++)
        ck_nx[c][r] = snoop(ck[c][r]);
    for (int r = 0; r < NUM_REGS; r++)
      rf_nx[r] = snoop(rf[r]);
    // Ascending slot order lets the highest slot win a shared rd; rename overrides CDB.
    for (int k = 0; k < ISSUE_W; k++) begin
      if (issue_valid[k] && rd_we[k] && !(ZERO_REG != 0 && rd_a[k] == '0)) begin
        rf_nx[rd_a[k]].valid = 1'b0;
        rf_nx[rd_a[k]].tag   = tag_a[k];
      end
    end
    if (ckpt_restore) begin
      for (int r = 0; r < NUM_REGS; r++)
        rf_nx[r] = ck_nx[ckpt_restore_id][r];
    end else if (ckpt_save) begin
      for (int r = 0; r < NUM_REGS; r++)
        ck_nx[ckpt_save_id][r] = rf_nx[r];
    end
    busy_nx = '0;
    for (int r = 0; r < NUM_REGS; r++)
      if (!rf_nx[r].valid) busy_nx = busy_nx + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        rf[r] <= '{value: DATA_W'(r), valid: 1'b1, tag: '0};
        for (int c = 0; c < NUM_CKPT; c++)
          ck[c][r] <= '{value: DATA_W'(r), valid: 1'b1, tag: '0};
      end
      busy_count <= '0;
    end else if (en) begin
      rf         <= rf_nx;
      ck         <= ck_nx;
      busy_count <= busy_nx;
    end
  end

endmodule

// File: tb/tb_rename_regfile_ckpt.sv
// Directed plus randomized bench for rename_regfile_ckpt against a flat array reference model.
module tb_rename_regfile_ckpt;
  localparam int NR = 32, DW = 32, TW = 8, IW = 2, CDW = 4, NC = 4, AW = 5, CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, en, ckpt_save, ckpt_restore;
  logic [CW-1:0]       ckpt_save_id, ckpt_restore_id;
  logic [IW-1:0]       issue_valid, rd_we, dtype_rs1, dtype_rs2;
  logic [IW*AW-1:0]    addr_rs1, addr_rs2, addr_rd;
  logic [IW*TW-1:0]    rd_tag;
  logic [IW*DW-1:0]    dout_rs1, dout_rs2;
  logic [CDW*TW-1:0]   cdb_tag;
  logic [CDW*DW-1:0]   cdb_data;
  logic [AW:0]         busy_count;

  logic          iv [IW];
  logic          we [IW];
  logic [AW-1:0] a1 [IW];
  logic [AW-1:0] a2 [IW];
  logic [AW-1:0] ad [IW];
  logic [TW-1:0] rt [IW];
  logic [TW-1:0] ct [CDW];
  logic [DW-1:0] cd [CDW];

  always_comb begin
    for (int k = 0; k < IW; k++) begin
      issue_valid[k]         = iv[k];
      rd_we[k]               = we[k];
      addr_rs1[k*AW +: AW]   = a1[k];
      addr_rs2[k*AW +: AW]   = a2[k];
      addr_rd[k*AW +: AW]    = ad[k];
      rd_tag[k*TW +: TW]     = rt[k];
    end
    for (int c = 0; c < CDW; c++) begin
      cdb_tag[c*TW +: TW]  = ct[c];
      cdb_data[c*DW +: DW] = cd[c];
    end
  end

  rename_regfile_ckpt dut (
    .clk(clk), .reset(reset), .en(en),
    .issue_valid(issue_valid), .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
    .addr_rd(addr_rd), .rd_we(rd_we), .rd_tag(rd_tag),
    .dout_rs1(dout_rs1), .dout_rs2(dout_rs2),
    .dtype_rs1(dtype_rs1), .dtype_rs2(dtype_rs2),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
    .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id),
    .busy_count(busy_count)
  );

  // Reference model: main map and checkpoint maps as plain arrays.
  logic [DW-1:0] mv [NR];
  logic          mb [NR];
  logic [TW-1:0] mt [NR];
  logic [DW-1:0] cv [NC][NR];
  logic          cb [NC][NR];
  logic [TW-1:0] ctg [NC][NR];

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  function automatic int cdb_hit(logic [TW-1:0] t);
    for (int c = 0; c < CDW; c++)
      if (ct[c] != 0 && ct[c] == t) return c;
    return -1;
  endfunction

  function automatic int model_busy();
    int n = 0;
    for (int r = 0; r < NR; r++) if (!mb[r]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      mv[r] = DW'(r); mb[r] = 1'b1; mt[r] = '0;
      for (int c = 0; c < NC; c++) begin
        cv[c][r] = DW'(r); cb[c][r] = 1'b1; ctg[c][r] = '0;
      end
    end
  endtask

  task automatic model_update();
    logic [DW-1:0] nv [NR];
    logic          nb [NR];
    logic [TW-1:0] nt [NR];
    int h;
    if (reset) begin model_reset(); return; end
    if (!en) return;
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++) begin
        h = cdb_hit(ctg[c][r]);
        if (!cb[c][r] && h >= 0) begin cv[c][r] = cd[h]; cb[c][r] = 1'b1; ctg[c][r] = '0; end
      end
    for (int r = 0; r < NR; r++) begin
      nv[r] = mv[r]; nb[r] = mb[r]; nt[r] = mt[r];
      h = cdb_hit(mt[r]);
      if (!mb[r] && h >= 0) begin nv[r] = cd[h]; nb[r] = 1'b1; nt[r] = '0; end
    end
    if (!ckpt_restore)
      for (int k = 0; k < IW; k++)
        if (iv[k] && we[k] && ad[k] != 0) begin nb[ad[k]] = 1'b0; nt[ad[k]] = rt[k]; end
    for (int r = 0; r < NR; r++) begin
      if (ckpt_restore) begin
        nv[r] = cv[ckpt_restore_id][r]; nb[r] = cb[ckpt_restore_id][r]; nt[r] = ctg[ckpt_restore_id][r];
      end else if (ckpt_save) begin
        cv[ckpt_save_id][r] = nv[r]; cb[ckpt_save_id][r] = nb[r]; ctg[ckpt_save_id][r] = nt[r];
      end
      mv[r] = nv[r]; mb[r] = nb[r]; mt[r] = nt[r];
    end
  endtask

  function automatic logic [DW:0] model_read(int k, logic [AW-1:0] s);
    int h;
    if (!iv[k]) return '0;
    if (s == 0) return '0;
    for (int j = k - 1; j >= 0; j--)
      if (iv[j] && we[j] && ad[j] == s) return {1'b1, 24'd0, rt[j]};
    if (mb[s]) return {1'b0, mv[s]};
    h = cdb_hit(mt[s]);
    if (h >= 0) return {1'b0, cd[h]};
    return {1'b1, 24'd0, mt[s]};
  endfunction

  task automatic idle();
    reset = 1'b0; en = 1'b1; ckpt_save = 1'b0; ckpt_restore = 1'b0;
    ckpt_save_id = '0; ckpt_restore_id = '0;
    for (int k = 0; k < IW; k++) begin iv[k] = 0; we[k] = 0; a1[k] = 0; a2[k] = 0; ad[k] = 0; rt[k] = 0; end
    for (int c = 0; c < CDW; c++) begin ct[c] = 0; cd[c] = 0; end
  endtask

  task automatic check_reads();
    #1;
    for (int k = 0; k < IW; k++) begin
      chk($sformatf("slot%0d_rs1", k), {dtype_rs1[k], dout_rs1[k*DW +: DW]}, model_read(k, a1[k]));
      chk($sformatf("slot%0d_rs2", k), {dtype_rs2[k], dout_rs2[k*DW +: DW]}, model_read(k, a2[k]));
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    chk("busy_count", busy_count, model_busy());
  endtask

  task automatic rename(input int k, input int r, input int t);
    iv[k] = 1; we[k] = 1; ad[k] = AW'(r); rt[k] = TW'(t);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    model_reset();
    tick(); tick();

    // Reset state and register-zero behaviour
    idle(); iv[0] = 1; a1[0] = 5; a2[0] = 0;
    check_reads();
    chk("t1_dout1", {dtype_rs1[0], dout_rs1[31:0]}, 33'd5);
    chk("t1_dout2", {dtype_rs2[0], dout_rs2[31:0]}, 33'd0);
    chk("t1_busy", busy_count, 0);

    // Rename then CDB bypass on the pending tag
    idle(); rename(0, 3, 8'h11); tick();
    idle(); iv[0] = 1; a1[0] = 3;
    check_reads();
    chk("t2_tag", {dtype_rs1[0], dout_rs1[31:0]}, {1'b1, 32'h11});
    chk("t2_busy", busy_count, 1);
    ct[2] = 8'h11; cd[2] = 32'hDEAD;
    check_reads();
    chk("t2_bypass", {dtype_rs1[0], dout_rs1[31:0]}, {1'b0, 32'hDEAD});
    tick();
    idle(); iv[0] = 1; a1[0] = 3;
    check_reads();
    chk("t2_after", {dtype_rs1[0], dout_rs1[31:0]}, {1'b0, 32'hDEAD});
    chk("t2_busy0", busy_count, 0);

    // Intra-bundle forwarding and same-rd double rename
    idle(); rename(0, 7, 8'h20); iv[1] = 1; a1[1] = 7;
    check_reads();
    chk("t3_fwd", {dtype_rs1[1], dout_rs1[63:32]}, {1'b1, 32'h20});
    tick();
    idle(); rename(0, 9, 8'h21); rename(1, 9, 8'h22); tick();
    idle(); iv[0] = 1; a1[0] = 9;
    check_reads();
    chk("t3_hiwin", {dtype_rs1[0], dout_rs1[31:0]}, {1'b1, 32'h22});

    // Rename beats CDB on the same register
    idle(); rename(0, 4, 8'h2F); tick();
    idle(); rename(0, 4, 8'h30); ct[0] = 8'h2F; cd[0] = 32'h5555; tick();
    idle(); iv[0] = 1; a1[0] = 4;
    check_reads();
    chk("t4_pend", {dtype_rs1[0], dout_rs1[31:0]}, {1'b1, 32'h30});

    // Drain outstanding tags, then checkpoint save / snoop / restore
    idle(); ct[0] = 8'h20; ct[1] = 8'h22; ct[2] = 8'h30; cd[0] = 1; cd[1] = 2; cd[2] = 3; tick();
    idle(); rename(0, 2, 8'h40); tick();
    idle(); ckpt_save = 1; ckpt_save_id = 1; tick();
    idle(); rename(0, 2, 8'h41); rename(1, 6, 8'h42); tick();
    idle(); ct[3] = 8'h40; cd[3] = 32'h1234; tick();
    idle(); ckpt_restore = 1; ckpt_restore_id = 1; tick();
    idle(); iv[0] = 1; a1[0] = 2; a2[0] = 6;
    check_reads();
    chk("t5_r2", {dtype_rs1[0], dout_rs1[31:0]}, {1'b0, 32'h1234});
    chk("t5_r6", {dtype_rs2[0], dout_rs2[31:0]}, {1'b0, 32'd6});
    chk("t5_busy", busy_count, 0);

    // Reset dominates a simultaneous restore and rename
    idle(); rename(0, 8, 8'h50); tick();
    idle(); reset = 1; ckpt_restore = 1; ckpt_restore_id = 1; rename(0, 5, 8'h51); tick();
    for (int r = 0; r < NR; r += 4) begin
      idle(); iv[0] = 1; iv[1] = 1;
      a1[0] = AW'(r); a2[0] = AW'(r + 1); a1[1] = AW'(r + 2); a2[1] = AW'(r + 3);
      check_reads();
      chk($sformatf("t6_r%0d", r),     {dtype_rs1[0], dout_rs1[31:0]},  33'(r));
      chk($sformatf("t6_r%0d", r + 1), {dtype_rs2[0], dout_rs2[31:0]},  33'(r + 1));
      chk($sformatf("t6_r%0d", r + 2), {dtype_rs1[1], dout_rs1[63:32]}, 33'(r + 2));
      chk($sformatf("t6_r%0d", r + 3), {dtype_rs2[1], dout_rs2[63:32]}, 33'(r + 3));
    end
    chk("t6_busy", busy_count, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      idle();
      en = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 249) == 0);
      for (int k = 0; k < IW; k++) begin
        iv[k] = 1'($urandom_range(0, 3) != 0);
        we[k] = 1'($urandom_range(0, 1));
        a1[k] = AW'($urandom); a2[k] = AW'($urandom);
        ad[k] = AW'($urandom_range(0, 7));
        rt[k] = TW'($urandom_range(1, 15));
      end
      for (int c = 0; c < CDW; c++) begin
        ct[c] = ($urandom_range(0, 1) != 0) ? TW'($urandom_range(1, 15)) : '0;
        cd[c] = $urandom;
      end
      ckpt_save = ($urandom_range(0, 4) == 0);
      ckpt_save_id = CW'($urandom);
      ckpt_restore = ($urandom_range(0, 14) == 0);
      ckpt_restore_id = CW'($urandom);
      check_reads();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rename_regfile_ckpt.md
Name: rename_regfile_ckpt

Overview:
- Parametrised successor to the dual-issue renaming register file of the Tomasulo core.
- Holds per architectural register: value, valid bit, rename tag. Supplies operands as value or tag to ISSUE_W issue slots, and resolves pending tags from CDB_W CDB channels.
- New features: same-cycle CDB bypass to read ports; intra-bundle dependency forwarding; NUM_CKPT snapshots for branch-mispredict recovery.

Parameters:
- NUM_REGS, 32, architectural registers (power of 2); AW = log2(NUM_REGS).
- DATA_W, 32, register data width.
- TAG_W, 8, rename tag width; tag 0 reserved as "no tag".
- ISSUE_W, 2, issue slots per cycle.
- CDB_W, 4, CDB broadcast channels.
- NUM_CKPT, 4, checkpoint slots; CW = log2(NUM_CKPT).
- ZERO_REG, 1, if 1, register 0 reads 0, is always valid, and is never renamed.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  global advance; when 0, state holds (reads still combinational).
- issue_valid  in  ISSUE_W  per-slot instruction valid.
- addr_rs1, addr_rs2, addr_rd  in  ISSUE_W*AW  per-slot source/dest indices, slot 0 in LSBs.
- rd_we  in  ISSUE_W  slot writes a destination.
- rd_tag  in  ISSUE_W*TAG_W  tag allocated by the arbiter per slot.
- dout_rs1, dout_rs2  out  ISSUE_W*DATA_W  operand value, or tag zero-extended.
- dtype_rs1, dtype_rs2  out  ISSUE_W  0 = data, 1 = tag.
- cdb_tag  in  CDB_W*TAG_W  broadcast tags; 0 = idle channel.
- cdb_data  in  CDB_W*DATA_W  broadcast data.
- ckpt_save  in  1  snapshot request.
- ckpt_save_id  in  CW  slot to write.
- ckpt_restore  in  1  recovery request.
- ckpt_restore_id  in  CW  slot to restore from.
- busy_count  out  AW+1  number of registers currently not valid (registered).

Behaviour:
- Reset: all regs value = index, valid = 1, tag = 0; all checkpoint slots are copies of this state; busy_count = 0.
- Outputs for a slot with issue_valid = 0 are data = 0, dtype = 0.
- Read port (combinational), for each valid slot k and source s. Priority, highest first:
  - (a) ZERO_REG and s == 0 -> data 0, dtype 0.
  - (b) Nearest lower slot j < k with issue_valid & rd_we and addr_rd == s -> rd_tag[j], dtype 1 (intra-bundle forwarding).
  - (c) Register valid -> stored value, dtype 0.
  - (d) Stored tag matches a nonzero cdb_tag[c] -> cdb_data[c], dtype 0 (bypass; lowest c wins on duplicates).
  - (e) Otherwise -> stored tag, dtype 1.
- Update (posedge clk, en = 1, no restore):
  - CDB: a register with valid = 0 whose tag equals a nonzero cdb_tag[c] takes value = cdb_data[c], valid = 1, tag = 0.
  - Rename: issue_valid & rd_we -> valid = 0, tag = rd_tag; value is left unchanged. Rename beats CDB on the same register.
  - Two slots renaming the same rd: the highest slot wins.
  - Rename to reg 0 is ignored when ZERO_REG = 1.
- Checkpoints:
  - Each slot stores {value, valid, tag} for all registers.
  - Every slot independently snoops the CDB with the same resolution rule, so stored snapshots stay current.
  - ckpt_save (en = 1): slot ckpt_save_id receives the post-update main state of this same cycle, i.e. it includes this cycle's renames and CDB writes.
- Restore (en = 1, ckpt_restore = 1):
  - The main map is loaded next cycle from slot ckpt_restore_id, including that slot's CDB resolution from this same cycle.
  - Issue-slot renames are ignored that cycle.
  - A simultaneous ckpt_save is ignored.
  - CDB snooping of the other checkpoint slots continues.
- en = 0: no state change, including checkpoint snooping (the upstream holds the CDB while stalled).
- reset dominates everything, including mid-restore.
- busy_count is updated each cycle from the next-state valid bits.

Test Plan:
1. Reset, then slot0 reads rs1 = 5, rs2 = 0 -> dout 5 / 0, dtype 0 / 0; busy_count = 0.
2. Cycle 1: slot0 renames r3 -> tag 0x11. Cycle 2: slot0 reads r3 -> dout 0x11, dtype 1; busy_count = 1. Cycle 2 also drives cdb ch2 tag 0x11, data 0xDEAD -> same-cycle read gives 0xDEAD, dtype 0; cycle 3 reg valid, busy_count = 0.
3. One bundle: slot0 renames r7 -> 0x20, slot1 reads rs1 = 7 -> slot1 gets 0x20, dtype 1. Both slots rename r9 (0x21, 0x22) -> next-cycle read of r9 shows 0x22.
4. Same cycle: CDB broadcasts the tag pending on r4 while slot0 renames r4 -> 0x30 -> r4 stays pending with tag 0x30.
5. Steps:
   - Save ckpt 1 with r2 pending on tag 0x40.
   - Rename r2 -> 0x41 and r6 -> 0x42.
   - CDB 0x40 with data 0x1234.
   - Restore ckpt 1.
   - Expected: r2 = 0x1234 valid; r6 valid with its original value; busy_count = 0.
6. Assert reset in the same cycle as ckpt_restore and a rename -> next cycle all registers at their index value, valid, tag 0.
